eth_decap: RTL and testbench
============================

// Module: eth_decap
// PURPOSE
//  Receive side of the TLP-over-UDP tunnel. Accepts 64-bit AXI-Stream Ethernet frames from the 10G MAC RX path.
//  Checks the fixed 48B Eth+IPv4+UDP+tcap header, then strips it.
//  Writes the TLP payload beats into the TLP FIFO using the same 74-bit word format the encapsulator reads.
//  Tracks the tcap 40-bit sequence number for gap detection.
// PARAMETERS
//  eth_addr   48'h00_11_22_33_44_55  local MAC; frame accepted if dst == eth_addr or 48'hFF_FF_FF_FF_FF_FF
//  ip_addr    {8'd192,8'd168,8'd11,8'd1}  local IPv4; ip.daddr must match
//  udp_port   16'h3776               udp.dest must match
//  tcap_ver   3'b001                 tcap.ver must match
// PORTS
//  clk156          in   1   156.25 MHz clock
//  sys_rst_n       in   1   reset, asynchronous assert, active-low
//  s_axis_tvalid   in   1   frame beat valid
//  s_axis_tready   out  1   frame beat accept
//  s_axis_tdata    in   64  wire byte k of beat at tdata[8k+7:8k]
//  s_axis_tkeep    in   8   byte enables (meaningful on last beat)
//  s_axis_tlast    in   1   last beat of frame
//  s_axis_tuser    in   1   MAC error flag (any beat)
//  wr_en           out  1   TLP FIFO write strobe
//  din             out  74  {tkeep[7:0], tdata[63:0], tlast, tuser}
//  full            in   1   TLP FIFO full
//  rx_pkt_cnt      out  32  frames forwarded
//  drop_cnt        out  32  frames dropped
//  seq_gap_cnt     out  32  forwarded frames whose ts != last_ts+1
//  last_ts         out  40  tcap ts of last forwarded frame
// BEHAVIOUR
//  Reset (async, sys_rst_n=0):
//   - state=RX_HDR, beat count=0, match flag=1.
//   - s_axis_tready=0, wr_en=0, din=0; all counters=0; last_ts=0; seq_valid=0.
//  States: RX_HDR (beats 0..5), RX_DATA, RX_DROP.
//  Beat transfer = s_axis_tvalid & s_axis_tready.
//  RX_HDR:
//   - tready=1; every transfer increments the beat count.
//   - The matching beat clears the match flag on any check failure:
//     - b0: bytes0-5 dst MAC.
//     - b1: bytes12-13 = 16'h0800; byte14 = 8'h45.
//     - b2: byte23 = 8'd17.
//     - b3: bytes30-31 = ip_addr[31:16].
//     - b4: bytes32-33 = ip_addr[15:0]; bytes36-37 = udp_port.
//     - b5: byte42[7:5] = tcap_ver; ts = bytes43..47, byte43 = ts[39:32].
//   - Multi-byte fields are big-endian on the wire. tuser=1 on any header beat clears the match flag.
//   - tlast on beats 0..5 (runt or header-only frame): drop_cnt+1, restart at RX_HDR beat 0.
//   - On beat 5 without tlast:
//     - Match set: go to RX_DATA; rx_pkt_cnt+1.
//       - If seq_valid and ts != last_ts+1 (mod 2^40): seq_gap_cnt+1.
//       - last_ts <= ts; seq_valid <= 1.
//     - Match clear: go to RX_DROP; drop_cnt+1.
//  RX_DATA:
//   - tready = ~full. Each transfer: wr_en=1, din={tkeep,tdata,tlast,tuser}, registered (1-cycle latency).
//   - tlast transfer: return to RX_HDR, beat 0, match=1.
//  RX_DROP:
//   - tready=1, no writes. tlast transfer: return to RX_HDR.
//  Boundaries:
//   - full=1 in RX_DATA: tready=0, wr_en=0, and the beat holds.
//   - full and tvalid may toggle in the same cycle; only the current-cycle full gates acceptance.
//   - Header beats are never written to the FIFO; the FIFO never sees a partial header.
//   - Counters wrap at 2^32. Frames ending in RX_DATA with tuser=1 are forwarded, with tuser passed in din[0].
//   - Reset mid-frame: the remainder of that frame is treated as a new frame and is dropped or runt-counted by the checks.
// TESTING
//  T1:
//   - Stimulus: valid frame (dst=eth_addr, ts=1), 4 payload beats, last tkeep=8'h0F.
//   - Expect: 4 wr_en pulses, last din[73:66]=8'h0F and din[1]=1; rx_pkt_cnt=1; last_ts=1.
//  T2:
//   - Stimulus: frames with udp dest=16'h1234, ip proto=6, and ethertype=16'h86DD.
//   - Expect: no writes; drop_cnt=3; tready held 1 throughout.
//  T3:
//   - Stimulus: 3-beat runt with tlast on beat 2, then a valid frame.
//   - Expect: drop_cnt=1; the valid frame is forwarded intact.
//  T4:
//   - Stimulus: valid frames with ts=5,6,8.
//   - Expect: seq_gap_cnt=1; last_ts=8.
//  T5:
//   - Stimulus: full=1 for 10 cycles at payload beat 2.
//   - Expect: tready=0 and no wr_en for those 10 cycles; data resumes in order with no loss or duplication.
//  T6:
//   - Stimulus: assert sys_rst_n=0 mid-payload, release, then send a valid frame.
//   - Expect: all outputs and counters at reset values; the new frame is forwarded with rx_pkt_cnt=1.

Source files
------------

// File: rtl/eth_decap.sv
// Receive side of the TLP-over-UDP tunnel: checks and strips the 48B
// Eth+IPv4+UDP+tcap header, then writes the payload beats into the TLP FIFO.
module eth_decap #(
   parameter logic [47:0] eth_addr = 48'h00_11_22_33_44_55,
   parameter logic [31:0] ip_addr  = {8'd192, 8'd168, 8'd11, 8'd1},
   parameter logic [15:0] udp_port = 16'h3776,
   parameter logic [2:0]  tcap_ver = 3'b001
) (
   input  logic        clk156,
   input  logic        sys_rst_n,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        wr_en,
   output logic [73:0] din,
   input  logic        full,
   output logic [31:0] rx_pkt_cnt,
   output logic [31:0] drop_cnt,
   output logic [31:0] seq_gap_cnt,
   output logic [39:0] last_ts
);

   typedef enum logic [1:0] {
      RX_HDR,
      RX_DATA,
      RX_DROP
   } state_t;

   state_t      state;
   logic [2:0]  beat;
   logic        match;
   logic        rdy_en;
   logic        seq_valid;
   logic        xfer;
   logic        field_ok;
   logic        match_nx;
   logic [47:0] dst;
   logic [39:0] ts;

   // Wire byte k sits at tdata[8k+7:8k]; fields are big-endian on the wire.
   assign dst = {s_axis_tdata[7:0],   s_axis_tdata[15:8],
                 s_axis_tdata[23:16], s_axis_tdata[31:24],
                 s_axis_tdata[39:32], s_axis_tdata[47:40]};

   assign ts = {s_axis_tdata[31:24], s_axis_tdata[39:32],
                s_axis_tdata[47:40], s_axis_tdata[55:48],
                s_axis_tdata[63:56]};

   always_comb begin
      field_ok = 1'b1;
      unique case (beat)
         3'd0: field_ok = (dst == eth_addr) ||
                          (dst == 48'hFF_FF_FF_FF_FF_FF);
         3'd1: field_ok = (s_axis_tdata[39:32] == 8'h08) &&
                          (s_axis_tdata[47:40] == 8'h00) &&
                          (s_axis_tdata[55:48] == 8'h45);
         3'd2: field_ok = (s_axis_tdata[63:56] == 8'd17);
         3'd3: field_ok = ({s_axis_tdata[55:48], s_axis_tdata[63:56]}
                           == ip_addr[31:16]);
         3'd4: field_ok = ({s_axis_tdata[7:0], s_axis_tdata[15:8]}
                           == ip_addr[15:0]) &&
                          ({s_axis_tdata[39:32], s_axis_tdata[47:40]}
                           == udp_port);
         3'd5: field_ok = (s_axis_tdata[23:21] == tcap_ver);
         default: field_ok = 1'b0;
      endcase
   end

   assign match_nx = match & field_ok & ~s_axis_tuser;

   // Held low for the first cycle out of reset; only payload waits on full.
   assign s_axis_tready = rdy_en & ((state == RX_DATA) ? ~full : 1'b1);
   assign xfer = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge clk156 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= RX_HDR;
         beat        <= 3'd0;
         match       <= 1'b1;
         rdy_en      <= 1'b0;
         seq_valid   <= 1'b0;
         wr_en       <= 1'b0;
         din         <= '0;
         rx_pkt_cnt  <= '0;
         drop_cnt    <= '0;
         seq_gap_cnt <= '0;
         last_ts     <= '0;
      end else begin
         rdy_en <= 1'b1;
         wr_en  <= 1'b0;
         unique case (state)
            RX_HDR: begin
               if (xfer) begin
                  if (s_axis_tlast) begin
                     drop_cnt <= drop_cnt + 32'd1;
                     beat     <= 3'd0;
                     match    <= 1'b1;
                  end else if (beat == 3'd5) begin
                     beat  <= 3'd0;
                     match <= 1'b1;
                     if (match_nx) begin
                        state      <= RX_DATA;
                        rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
                        if (seq_valid && (ts != last_ts + 40'd1))
                           seq_gap_cnt <= seq_gap_cnt + 32'd1;
                        last_ts   <= ts;
                        seq_valid <= 1'b1;
                     end else begin
                        state    <= RX_DROP;
                        drop_cnt <= drop_cnt + 32'd1;
                     end
                  end else begin
                     beat  <= beat + 3'd1;
                     match <= match_nx;
                  end
               end
            end
            RX_DATA: begin
               if (xfer) begin
                  wr_en <= 1'b1;
                  din   <= {s_axis_tkeep, s_axis_tdata,
                            s_axis_tlast, s_axis_tuser};
                  if (s_axis_tlast)
                     state <= RX_HDR;
               end
            end
            RX_DROP: begin
               if (xfer && s_axis_tlast)
                  state <= RX_HDR;
            end
            default: state <= RX_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_decap.sv
// Directed bench for eth_decap: scoreboarded payload writes plus counter,
// sequence-gap, back-pressure and reset checks.
`timescale 1ns/1ps
module tb_eth_decap;

   logic        clk156 = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic        wr_en;
   logic [73:0] din;
   logic        full = 1'b0;
   logic [31:0] rx_pkt_cnt;
   logic [31:0] drop_cnt;
   logic [31:0] seq_gap_cnt;
   logic [39:0] last_ts;

   always #5 clk156 = ~clk156;

   eth_decap dut (
      .clk156        (clk156),
      .sys_rst_n     (sys_rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .wr_en         (wr_en),
      .din           (din),
      .full          (full),
      .rx_pkt_cnt    (rx_pkt_cnt),
      .drop_cnt      (drop_cnt),
      .seq_gap_cnt   (seq_gap_cnt),
      .last_ts       (last_ts)
   );

   int          checks = 0;
   int          errors = 0;
   int          wr_seen = 0;
   logic [73:0] expq[$];
   logic [63:0] hb[6];
   int          exp_rx = 0;
   int          exp_drop = 0;
   int          exp_gap = 0;
   logic [39:0] m_last = '0;
   bit          m_valid = 1'b0;
   bit          saw_busy = 1'b0;

   task automatic chk(input string tag, input logic [73:0] obs,
                      input logic [73:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every FIFO write must match the oldest queued payload beat.
   always @(negedge clk156) begin
      if (sys_rst_n && wr_en === 1'b1) begin
         wr_seen++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_write observed=%h expected=none", din);
         end else begin
            chk("din", din, expq.pop_front());
         end
      end
   end

   task automatic step();
      @(negedge clk156);
      #1;
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
      bit done;
      done = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      for (int n = 0; n < 200 && !done; n++) begin
         #1;
         done = s_axis_tready;
         if (!done) saw_busy = 1'b1;
         step();
      end
      if (!done) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=stalled expected=accept");
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic mk_hdr(input logic [47:0] dst, input logic [15:0] et,
                         input logic [7:0] pr, input logic [15:0] dp,
                         input logic [2:0] ver, input logic [39:0] ts);
      logic [7:0] h[48];
      for (int i = 0; i < 48; i++) h[i] = 8'(i * 7 + 3);
      for (int i = 0; i < 6; i++) h[i] = dst[47-8*i -: 8];
      h[12] = et[15:8];
      h[13] = et[7:0];
      h[14] = 8'h45;
      h[23] = pr;
      h[30] = 8'd192;
      h[31] = 8'd168;
      h[32] = 8'd11;
      h[33] = 8'd1;
      h[36] = dp[15:8];
      h[37] = dp[7:0];
      h[42] = {ver, 5'b10101};
      for (int i = 0; i < 5; i++) h[43+i] = ts[39-8*i -: 8];
      for (int k = 0; k < 6; k++)
         for (int j = 0; j < 8; j++)
            hb[k][8*j +: 8] = h[8*k+j];
   endtask

   task automatic mk_good(input logic [39:0] ts);
      mk_hdr(48'h00_11_22_33_44_55, 16'h0800, 8'd17, 16'h3776, 3'b001, ts);
   endtask

   task automatic model_fwd(input logic [39:0] ts);
      exp_rx++;
      if (m_valid && ts != m_last + 40'd1) exp_gap++;
      m_last  = ts;
      m_valid = 1'b1;
   endtask

   task automatic send_frame(input int npay, input logic [7:0] lk,
                             input logic ul, input logic hu,
                             input bit fwd, input logic [39:0] ts);
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
      for (int b = 0; b < 6; b++)
         send(hb[b], 8'hFF, (npay == 0 && b == 5), (b == 3) ? hu : 1'b0);
      for (int p = 0; p < npay; p++) begin
         d = {$urandom, $urandom};
         l = (p == npay - 1);
         k = l ? lk : 8'hFF;
         u = l ? ul : 1'b0;
         if (fwd) expq.push_back({k, d, l, u});
         send(d, k, l, u);
      end
      if (fwd) model_fwd(ts);
      else exp_drop++;
   endtask

   task automatic drain_and_check(input string tag);
      repeat (3) step();
      chk({tag, "_qempty"}, 74'(expq.size()), 74'(0));
      chk({tag, "_rx"}, 74'(rx_pkt_cnt), 74'(exp_rx));
      chk({tag, "_drop"}, 74'(drop_cnt), 74'(exp_drop));
      chk({tag, "_gap"}, 74'(seq_gap_cnt), 74'(exp_gap));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tready"}, 74'(s_axis_tready), 74'(0));
      chk({tag, "_wr_en"}, 74'(wr_en), 74'(0));
      chk({tag, "_din"}, din, 74'(0));
      chk({tag, "_rx"}, 74'(rx_pkt_cnt), 74'(0));
      chk({tag, "_drop"}, 74'(drop_cnt), 74'(0));
      chk({tag, "_gap"}, 74'(seq_gap_cnt), 74'(0));
      chk({tag, "_last_ts"}, 74'(last_ts), 74'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          snap;
      logic [63:0] d2;

      step();
      chk_reset_vals("reset");
      sys_rst_n = 1'b1;
      step();

      // T1: single valid frame, short last beat
      snap = wr_seen;
      mk_good(40'd1);
      send_frame(4, 8'h0F, 1'b0, 1'b0, 1'b1, 40'd1);
      drain_and_check("t1");
      chk("t1_writes", 74'(wr_seen - snap), 74'(4));
      chk("t1_keep", 74'(din[73:66]), 74'(8'h0F));
      chk("t1_tlast", 74'(din[1]), 74'(1));
      chk("t1_last_ts", 74'(last_ts), 74'(1));

      // T2: bad udp dest, ip proto, ethertype
      snap = wr_seen;
      saw_busy = 1'b0;
      mk_hdr(48'h00_11_22_33_44_55, 16'h0800, 8'd17, 16'h1234, 3'b001, 40'd7);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd7);
      mk_hdr(48'h00_11_22_33_44_55, 16'h0800, 8'd6, 16'h3776, 3'b001, 40'd7);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd7);
      mk_hdr(48'h00_11_22_33_44_55, 16'h86DD, 8'd17, 16'h3776, 3'b001, 40'd7);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd7);
      drain_and_check("t2");
      chk("t2_drop3", 74'(drop_cnt), 74'(3));
      chk("t2_nowrites", 74'(wr_seen - snap), 74'(0));
      chk("t2_tready_held", 74'(saw_busy), 74'(0));

      // Extra drops: wrong dst, wrong tcap ver, tuser on a header beat
      mk_hdr(48'h00_11_22_33_44_56, 16'h0800, 8'd17, 16'h3776, 3'b001, 40'd7);
      send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd7);
      mk_hdr(48'h00_11_22_33_44_55, 16'h0800, 8'd17, 16'h3776, 3'b010, 40'd7);
      send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd7);
      mk_good(40'd7);
      send_frame(1, 8'hFF, 1'b0, 1'b1, 1'b0, 40'd7);
      drain_and_check("hdr_drops");

      // T3: runt, header-only frame, then a valid frame
      mk_good(40'd2);
      send(hb[0], 8'hFF, 1'b0, 1'b0);
      send(hb[1], 8'hFF, 1'b0, 1'b0);
      send(hb[2], 8'hFF, 1'b1, 1'b0);
      exp_drop++;
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 40'd2);
      send_frame(3, 8'h01, 1'b0, 1'b0, 1'b1, 40'd2);
      drain_and_check("t3");
      chk("t3_last_ts", 74'(last_ts), 74'(2));

      // T4: ts 5,6,8; ts=6 is broadcast and carries tuser on its last beat
      snap = exp_gap;
      mk_good(40'd5);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 40'd5);
      mk_hdr(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 8'd17, 16'h3776, 3'b001, 40'd6);
      send_frame(2, 8'h07, 1'b1, 1'b0, 1'b1, 40'd6);
      chk("t4_tuser_fwd", 74'(din[0]), 74'(1));
      mk_good(40'd8);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 40'd8);
      drain_and_check("t4");
      chk("t4_gaps", 74'(exp_gap - snap), 74'(2));
      chk("t4_last_ts", 74'(last_ts), 74'(8));

      // T5: FIFO full for 10 cycles at payload beat 2
      mk_good(40'd9);
      for (int b = 0; b < 6; b++) send(hb[b], 8'hFF, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
         d2 = {$urandom, $urandom};
         expq.push_back({8'hFF, d2, 1'b0, 1'b0});
         send(d2, 8'hFF, 1'b0, 1'b0);
      end
      d2 = {$urandom, $urandom};
      full = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d2;
      s_axis_tkeep  = 8'hFF;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      snap = wr_seen;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t5_tready", 74'(s_axis_tready), 74'(0));
         chk("t5_wr_en", 74'(wr_en), 74'(0));
      end
      chk("t5_nowrites", 74'(wr_seen - snap), 74'(0));
      full = 1'b0;
      expq.push_back({8'hFF, d2, 1'b0, 1'b0});
      send(d2, 8'hFF, 1'b0, 1'b0);
      for (int p = 0; p < 2; p++) begin
         d2 = {$urandom, $urandom};
         expq.push_back({(p == 1) ? 8'h3F : 8'hFF, d2, (p == 1), 1'b0});
         send(d2, (p == 1) ? 8'h3F : 8'hFF, (p == 1), 1'b0);
      end
      model_fwd(40'd9);
      drain_and_check("t5");

      // T6: reset mid-payload, remainder counted as a runt, then a frame
      mk_good(40'd50);
      send_frame(2, 8'hFF, 1'b0, 1'b0, 1'b1, 40'd50);
      mk_good(40'd51);
      for (int b = 0; b < 6; b++) send(hb[b], 8'hFF, 1'b0, 1'b0);
      d2 = {$urandom, $urandom};
      expq.push_back({8'hFF, d2, 1'b0, 1'b0});
      send(d2, 8'hFF, 1'b0, 1'b0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      sys_rst_n = 1'b0;
      #1;
      chk_reset_vals("t6_rst");
      expq.delete();
      exp_rx = 0;
      exp_drop = 0;
      exp_gap = 0;
      m_valid = 1'b0;
      m_last = '0;
      step();
      step();
      s_axis_tvalid = 1'b0;
      sys_rst_n = 1'b1;
      send({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
      send({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0);
      exp_drop++;
      mk_good(40'd100);
      send_frame(3, 8'hFF, 1'b0, 1'b0, 1'b1, 40'd100);
      drain_and_check("t6");
      chk("t6_rx1", 74'(rx_pkt_cnt), 74'(1));
      chk("t6_last_ts", 74'(last_ts), 74'(100));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
